// File: rtl/sigma_delta_dac_mc.sv
// Multi-channel sigma-delta DAC: linear sample interpolation, 1st/2nd-order loop, valid/ready input.
// Optional TPDF dither: define SIGMA_DELTA_DAC_DITHER_EN.
module sigma_delta_dac_mc #(
  parameter int unsigned W           = 16,
  parameter int unsigned CH          = 2,
  parameter int unsigned ORDER       = 2,
  parameter int unsigned SIGNED_IN   = 0,
  parameter int unsigned INTERP_LOG2 = 4
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [CH*W-1:0] DACin,
  input  logic            DACin_valid,
  output logic            DACin_ready,
  output logic [CH-1:0]   DACout
);

  localparam int unsigned L  = INTERP_LOG2;
  localparam int unsigned CW = W + L;
  localparam int unsigned SW = CW + 1;
  localparam int unsigned IW = W + 4;
  localparam int unsigned XW = IW + 2;
  localparam logic signed [XW-1:0] Fs = XW'(1) << (W - 1);

  if (ORDER != 1 && ORDER != 2) begin : g_order_check
    $error("sigma_delta_dac_mc: ORDER must be 1 or 2");
  end

  // Clamp a widened sum back into the integrator range instead of wrapping.
  function automatic logic signed [IW-1:0] sat(input logic signed [XW-1:0] v);
    if (v[XW-1:IW-1] == '0 || v[XW-1:IW-1] == '1) begin
      return v[IW-1:0];
    end else if (v[XW-1]) begin
      return {1'b1, {(IW - 1){1'b0}}};
    end else begin
      return {1'b0, {(IW - 1){1'b1}}};
    end
  endfunction

  logic                xfer;
  logic signed [W-1:0] x_in  [CH];
  logic signed [W-1:0] x_int [CH];

  assign xfer = DACin_valid && DACin_ready;

  for (genvar c = 0; c < CH; c++) begin : g_conv
    if (SIGNED_IN != 0) begin : g_twos
      assign x_in[c] = DACin[c*W +: W];
    end else begin : g_offset
      assign x_in[c] = {~DACin[c*W + W - 1], DACin[c*W +: W-1]};
    end
  end

  if (L > 0) begin : g_interp
    logic [L:0] ramp_cnt;
    logic       ramp_active;
    logic       ramp_last;

    assign ramp_active = (ramp_cnt != '0);
    assign ramp_last   = (ramp_cnt == {{L{1'b0}}, 1'b1});
    assign DACin_ready = ~ramp_active;

    always_ff @(posedge CLK) begin
      if (RESET) begin
        ramp_cnt <= '0;
      end else if (ramp_active) begin
        ramp_cnt <= ramp_cnt - 1'b1;
      end else if (DACin_valid) begin
        ramp_cnt <= {1'b1, {L{1'b0}}};
      end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
      logic signed [W-1:0]  target;
      logic signed [CW-1:0] cur;
      logic signed [SW-1:0] step;
      logic signed [SW-1:0] diff;
      logic signed [SW-1:0] step_next;

      assign diff      = {x_in[c][W-1], x_in[c], {L{1'b0}}} - {cur[CW-1], cur};
      assign step_next = diff >>> L;

      always_ff @(posedge CLK) begin
        if (RESET) begin
          target <= '0;
          cur    <= '0;
          step   <= '0;
        end else if (ramp_active) begin
          // Last step lands exactly on the target, whatever rounding the step had.
          cur <= ramp_last ? {target, {L{1'b0}}} : CW'(cur + step);
        end else if (xfer) begin
          target <= x_in[c];
          step   <= step_next;
        end
      end

      assign x_int[c] = cur[CW-1:L];
    end
  end else begin : g_direct
    assign DACin_ready = 1'b1;

    for (genvar c = 0; c < CH; c++) begin : g_ch
      logic signed [W-1:0] cur;

      always_ff @(posedge CLK) begin
        if (RESET) begin
          cur <= '0;
        end else if (xfer) begin
          cur <= x_in[c];
        end
      end

      assign x_int[c] = cur;
    end
  end

`ifdef SIGMA_DELTA_DAC_DITHER_EN
  if (2 * CH > 24) begin : g_dither_check
    $error("sigma_delta_dac_mc: dither supports at most 12 channels");
  end

  logic [23:0] lfsr;

  // Right-shifting Galois form of x^24 + x^23 + x^22 + x^17 + 1.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      lfsr <= 24'h000001;
    end else begin
      lfsr <= {1'b0, lfsr[23:1]} ^ (lfsr[0] ? 24'hE10000 : 24'h000000);
    end
  end
`endif

  for (genvar c = 0; c < CH; c++) begin : g_mod
    logic signed [XW-1:0] x_ext;
    logic signed [XW-1:0] fb;
    logic signed [XW-1:0] sum1;
    logic signed [IW-1:0] i1;
    logic signed [IW-1:0] i1_next;
    logic                 out;

`ifdef SIGMA_DELTA_DAC_DITHER_EN
    logic signed [XW-1:0] dither;
    assign dither = XW'(lfsr[2*c]) - XW'(lfsr[2*c+1]);
    assign x_ext  = {{(XW - W){x_int[c][W-1]}}, x_int[c]} + dither;
`else
    assign x_ext = {{(XW - W){x_int[c][W-1]}}, x_int[c]};
`endif

    assign fb        = out ? Fs : -Fs;
    assign sum1      = {{2{i1[IW-1]}}, i1} + x_ext - fb;
    assign i1_next   = sat(sum1);
    assign DACout[c] = out;

    if (ORDER == 1) begin : g_first
      always_ff @(posedge CLK) begin
        if (RESET) begin
          i1  <= '0;
          out <= 1'b0;
        end else begin
          i1  <= i1_next;
          out <= ~i1_next[IW-1];
        end
      end
    end else begin : g_second
      logic signed [XW-1:0] sum2;
      logic signed [IW-1:0] i2;
      logic signed [IW-1:0] i2_next;

      assign sum2    = {{2{i2[IW-1]}}, i2} + {{2{i1_next[IW-1]}}, i1_next} - fb;
      assign i2_next = sat(sum2);

      always_ff @(posedge CLK) begin
        if (RESET) begin
          i1  <= '0;
          i2  <= '0;
          out <= 1'b0;
        end else begin
          i1  <= i1_next;
          i2  <= i2_next;
          out <= ~i2_next[IW-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_sigma_delta_dac_mc.sv
// Bench for sigma_delta_dac_mc: two configurations share one stimulus stream; a cycle
// reference model feeds a scoreboard, plus density and handshake checks.
module tb_sigma_delta_dac_mc;

  localparam longint FS   = 32768;
  localparam longint IMAX = (64'sd1 <<< 19) - 1;

  logic        CLK;
  logic        RESET;
  logic [31:0] DACin;
  logic        DACin_valid;
  logic        rdy_a;
  logic        rdy_b;
  logic [1:0]  out_a;
  logic [1:0]  out_b;

  int n_checks = 0;
  int n_err    = 0;

  sigma_delta_dac_mc #(
    .W(16), .CH(2), .ORDER(2), .SIGNED_IN(0), .INTERP_LOG2(4)
  ) dut_a (
    .CLK(CLK), .RESET(RESET), .DACin(DACin), .DACin_valid(DACin_valid),
    .DACin_ready(rdy_a), .DACout(out_a)
  );

  sigma_delta_dac_mc #(
    .W(16), .CH(2), .ORDER(1), .SIGNED_IN(1), .INTERP_LOG2(0)
  ) dut_b (
    .CLK(CLK), .RESET(RESET), .DACin(DACin), .DACin_valid(DACin_valid),
    .DACin_ready(rdy_b), .DACout(out_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Configuration of instance k (0 = dut_a, 1 = dut_b)
  function automatic int ord_of(input int k);
    return (k == 0) ? 2 : 1;
  endfunction
  function automatic bit sgn_of(input int k);
    return k != 0;
  endfunction
  function automatic int lg_of(input int k);
    return (k == 0) ? 4 : 0;
  endfunction

  // Reference model state: integer values, cur scaled by 2^lg
  longint m_cur [2][2];
  longint m_step[2][2];
  longint m_tgt [2][2];
  longint m_i1  [2][2];
  longint m_i2  [2][2];
  bit     m_out [2][2];
  int     m_rcnt[2];
`ifdef SIGMA_DELTA_DAC_DITHER_EN
  logic [23:0] m_lfsr = 24'h000001;
`endif

  logic [5:0] exp_q[$];
  logic [5:0] mon_got;
  logic [5:0] mon_want;

  function automatic longint clamp(input longint v);
    if (v > IMAX) return IMAX;
    if (v < -IMAX - 1) return -IMAX - 1;
    return v;
  endfunction

  function automatic longint conv(input int k, input logic [15:0] s);
    if (sgn_of(k)) return longint'($signed(s));
    return longint'(s) - FS;
  endfunction

  function automatic bit model_ready(input int k);
    return (lg_of(k) == 0) || (m_rcnt[k] == 0);
  endfunction

  function automatic void model_step(input int k);
    longint x, fb, i1n, i2n;
    bit     xfer;
    int     lg;
    lg = lg_of(k);
    if (RESET) begin
      for (int c = 0; c < 2; c++) begin
        m_cur[k][c] = 0; m_step[k][c] = 0; m_tgt[k][c] = 0;
        m_i1[k][c] = 0; m_i2[k][c] = 0; m_out[k][c] = 1'b0;
      end
      m_rcnt[k] = 0;
      return;
    end
    for (int c = 0; c < 2; c++) begin
      x = m_cur[k][c] >>> lg;
`ifdef SIGMA_DELTA_DAC_DITHER_EN
      x = x + longint'(m_lfsr[2*c]) - longint'(m_lfsr[2*c+1]);
`endif
      fb  = m_out[k][c] ? FS : -FS;
      i1n = clamp(m_i1[k][c] + x - fb);
      if (ord_of(k) == 1) begin
        m_out[k][c] = (i1n >= 0);
      end else begin
        i2n = clamp(m_i2[k][c] + i1n - fb);
        m_i2[k][c]  = i2n;
        m_out[k][c] = (i2n >= 0);
      end
      m_i1[k][c] = i1n;
    end
    xfer = DACin_valid && model_ready(k);
    if (lg == 0) begin
      if (xfer) for (int c = 0; c < 2; c++) m_cur[k][c] = conv(k, DACin[c*16 +: 16]);
    end else if (m_rcnt[k] != 0) begin
      m_rcnt[k] = m_rcnt[k] - 1;
      for (int c = 0; c < 2; c++)
        m_cur[k][c] = (m_rcnt[k] == 0) ? m_tgt[k][c] * (64'sd1 <<< lg)
                                        : m_cur[k][c] + m_step[k][c];
    end else if (xfer) begin
      for (int c = 0; c < 2; c++) begin
        m_tgt[k][c]  = conv(k, DACin[c*16 +: 16]);
        m_step[k][c] = (m_tgt[k][c] * (64'sd1 <<< lg) - m_cur[k][c]) >>> lg;
      end
      m_rcnt[k] = 1 << lg;
    end
  endfunction

  always @(posedge CLK) begin
    model_step(0);
    model_step(1);
`ifdef SIGMA_DELTA_DAC_DITHER_EN
    if (RESET) m_lfsr = 24'h000001;
    else m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 24'hE10000 : 24'h000000);
`endif
    exp_q.push_back({model_ready(0), m_out[0][1], m_out[0][0],
                     model_ready(1), m_out[1][1], m_out[1][0]});
  end

  // Scoreboard monitor
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      mon_want = exp_q.pop_front();
      mon_got  = {rdy_a, out_a, rdy_b, out_b};
      n_checks++;
      if (mon_got !== mon_want) begin
        n_err++;
        $display("FAIL scoreboard t=%0t: {rdyA,outA,rdyB,outB} got %b want %b",
                 $time, mon_got, mon_want);
      end
    end
  end

  task automatic check_eq(input string name, input int act, input int want);
    n_checks++;
    if (act != want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic count_ones(input int n, output int a0, output int a1,
                            output int b0, output int b1);
    a0 = 0; a1 = 0; b0 = 0; b1 = 0;
    repeat (n) begin
      @(negedge CLK);
      a0 += int'(out_a[0]); a1 += int'(out_a[1]);
      b0 += int'(out_b[0]); b1 += int'(out_b[1]);
    end
  endtask

  task automatic wait_ready_a();
    int guard = 0;
    while (!rdy_a && guard < 100) begin
      guard++;
      @(negedge CLK);
    end
    check_eq("wait_ready_a", int'(rdy_a), 1);
  endtask

  task automatic do_xfer(input logic [31:0] d);
    wait_ready_a();
    DACin       = d;
    DACin_valid = 1'b1;
    @(negedge CLK);
    DACin_valid = 1'b0;
  endtask

  task automatic measure_low(output int n);
    n = 0;
    while (!rdy_a && n < 100) begin
      n++;
      @(negedge CLK);
    end
  endtask

  initial begin
    int a0, a1, b0, b1, n;
    RESET       = 1'b1;
    DACin       = {2{16'h8000}};
    DACin_valid = 1'b0;
    repeat (3) @(negedge CLK);
    check_eq("reset_ready_a", int'(rdy_a), 1);
    check_eq("reset_ready_b", int'(rdy_b), 1);
    check_eq("reset_out_a", int'(out_a), 0);
    check_eq("reset_out_b", int'(out_b), 0);
    RESET = 1'b0;

    // Idle at mid-scale: half density everywhere
    count_ones(4096, a0, a1, b0, b1);
    check_range("idle_a0", a0, 2046, 2050);
    check_range("idle_a1", a1, 2046, 2050);
    check_range("idle_b0", b0, 2046, 2050);
    check_range("idle_b1", b1, 2046, 2050);

    // 0xC000: 0.75 offset-binary on A, -0.5 FS (0.25) two's complement on B
    do_xfer({2{16'hC000}});
    repeat (80) @(negedge CLK);
    count_ones(4096, a0, a1, b0, b1);
    check_range("c000_a0", a0, 3068, 3076);
    check_range("c000_a1", a1, 3068, 3076);
    check_range("c000_b0", b0, 1020, 1028);
    check_range("c000_b1", b1, 1020, 1028);

    // Handshake: ramp length, and a held valid is taken as soon as ready returns
    do_xfer({2{16'h8000}});
    wait_ready_a();
    DACin       = {2{16'hC000}};
    DACin_valid = 1'b1;
    @(negedge CLK);
    measure_low(n);
    check_eq("ramp_len", n, 16);
    @(negedge CLK);
    check_eq("held_valid_reaccept", int'(rdy_a), 0);
    measure_low(n);
    check_eq("ramp_len_held", n, 16);
    DACin_valid = 1'b0;

    // Channel independence with opposite full-scale codes
    do_xfer({16'h8000, 16'h7FFF});
    wait_ready_a();
    repeat (80) @(negedge CLK);
    count_ones(4096, a0, a1, b0, b1);
    check_range("indep_b0_high", b0, 4090, 4096);
    check_range("indep_b1_low", b1, 0, 6);
    check_range("indep_a0", a0, 2044, 2052);
    check_range("indep_a1", a1, 2044, 2052);

    do_xfer({16'h0000, 16'hFFFF});
    wait_ready_a();
    repeat (80) @(negedge CLK);
    count_ones(4096, a0, a1, b0, b1);
    check_range("fullscale_a0_high", a0, 4092, 4096);
    check_range("fullscale_a1_low", a1, 0, 4);
    check_range("fullscale_b0", b0, 2044, 2052);
    check_range("fullscale_b1", b1, 2044, 2052);

    // Reset mid-ramp with a pending sample
    do_xfer({2{16'hA000}});
    repeat (6) @(negedge CLK);
    DACin_valid = 1'b1;
    RESET       = 1'b1;
    @(negedge CLK);
    RESET       = 1'b0;
    DACin_valid = 1'b0;
    check_eq("midramp_rst_ready_a", int'(rdy_a), 1);
    check_eq("midramp_rst_out_a", int'(out_a), 0);
    check_eq("midramp_rst_out_b", int'(out_b), 0);
    @(negedge CLK);
    check_eq("pending_dropped", int'(rdy_a), 1);
    do_xfer({2{16'h4000}});
    measure_low(n);
    check_eq("ramp_after_reset", n, 16);

    // Randomised traffic, checked by the scoreboard
    for (int i = 0; i < 3000; i++) begin
      RESET       = ($urandom_range(0, 249) == 0);
      DACin_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       DACin = {16'hFFFF, 16'h0000};
        1:       DACin = {16'h8000, 16'h7FFF};
        default: DACin = $urandom;
      endcase
      @(negedge CLK);
    end
    RESET       = 1'b0;
    DACin_valid = 1'b0;
    repeat (4) @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: stimulus did not complete by t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
